// File: rtl/fp_fma_add_arbiter.sv
// FMA-addend FIFO arbitrated against direct FP adds onto one fp_add issue port,
// with a bounded-starvation streak counter. Optional same-cycle bypass: FP_FMA_BYPASS_EN.
module fp_fma_add_arbiter #(
  parameter int PAYLOAD_W  = 128,
  parameter int ID_W       = 3,
  parameter int DEPTH      = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fma_valid_in,
  output logic                         fma_ready_out,
  input  logic [PAYLOAD_W-1:0]         fma_payload_in,
  input  logic [ID_W-1:0]              fma_id_in,
  input  logic                         add_pending,
  input  logic                         add_request,
  input  logic [PAYLOAD_W-1:0]         add_payload,
  input  logic [ID_W-1:0]              add_id,
  output logic                         add_ready_out,
  input  logic                         adder_ready,
  output logic                         adder_new_request,
  output logic [PAYLOAD_W-1:0]         adder_payload,
  output logic [ID_W-1:0]              adder_id,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         force_add
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STK_W   = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam int ENT_W   = ID_W + PAYLOAD_W;
  localparam bit FAIR_EN = (MAX_STREAK != 0);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STK_W-1:0] streak;
  logic [ENT_W-1:0] head;

  logic fifo_empty;
  logic bypass_take;
  logic grant_fifo, grant_bypass, grant_add, fma_grant;
  logic push, pop;

  assign fifo_empty = (count == '0);
  assign fifo_count = count;
  assign head       = mem[rd_ptr];

  assign force_add = FAIR_EN & add_pending & (streak == STK_W'(MAX_STREAK));

`ifdef FP_FMA_BYPASS_EN
  assign bypass_take = fma_valid_in & fifo_empty & adder_ready & ~force_add;
`else
  assign bypass_take = 1'b0;
`endif

  assign add_ready_out = adder_ready & (fifo_empty | force_add) & ~bypass_take;

  // A forced add blocks the FIFO head outright, so the FIFO term already
  // excludes that case; bypass is only possible with an empty FIFO.
  always_comb begin
    grant_fifo   = ~fifo_empty & adder_ready & ~force_add;
    grant_bypass = bypass_take & ~grant_fifo;
    grant_add    = (force_add & add_request) |
                   (~grant_fifo & ~grant_bypass & add_request);
    fma_grant    = grant_fifo | grant_bypass;
  end

  assign pop           = grant_fifo;
  assign fma_ready_out = (count < CNT_W'(DEPTH)) | pop;
  assign push          = fma_valid_in & fma_ready_out & ~bypass_take;

  always_comb begin
    adder_new_request = grant_add | fma_grant;
    adder_payload     = head[PAYLOAD_W-1:0];
    adder_id          = head[ENT_W-1:PAYLOAD_W];
    if (grant_add) begin
      adder_payload = add_payload;
      adder_id      = add_id;
    end else if (grant_bypass) begin
      adder_payload = fma_payload_in;
      adder_id      = fma_id_in;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {fma_id_in, fma_payload_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (!add_pending || grant_add) begin
      streak <= '0;
    end else if (fma_grant && (streak != STK_W'(MAX_STREAK))) begin
      streak <= streak + STK_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_fma_add_arbiter.sv
// Directed cycle-vector bench for fp_fma_add_arbiter: one instance with a short
// fairness streak, one with strict FMA priority.
module tb_fp_fma_add_arbiter;

  localparam int PW = 128;
  localparam int IW = 3;

  typedef struct {
    logic       rst, fv;
    logic [2:0] fid;
    logic       ap, areq;
    logic [2:0] aid;
    logic       rdy;
    logic       e_fr, e_ar, e_nr;
    logic [2:0] e_id;
    logic       e_add;
    logic [1:0] e_cnt;
    logic       e_force;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance F: DEPTH=2, MAX_STREAK=2
  logic f_rst, f_fv, f_ap, f_areq, f_rdy;
  logic [IW-1:0] f_fid, f_aid;
  logic f_fr, f_ar, f_nr, f_force;
  logic [PW-1:0] f_pay;
  logic [IW-1:0] f_id;
  logic [1:0] f_cnt;

  // instance S: DEPTH=2, MAX_STREAK=0
  logic s_rst, s_fv, s_ap, s_areq, s_rdy;
  logic [IW-1:0] s_fid, s_aid;
  logic s_fr, s_ar, s_nr, s_force;
  logic [PW-1:0] s_pay;
  logic [IW-1:0] s_id;
  logic [1:0] s_cnt;

  function automatic logic [PW-1:0] fpay(input logic [2:0] id);
    return {16{5'b10100, id}};
  endfunction

  function automatic logic [PW-1:0] apay(input logic [2:0] id);
    return {16{5'b01011, id}};
  endfunction

  fp_fma_add_arbiter #(.PAYLOAD_W(PW), .ID_W(IW), .DEPTH(2), .MAX_STREAK(2)) dut_f (
    .clk(clk), .rst(f_rst),
    .fma_valid_in(f_fv), .fma_ready_out(f_fr),
    .fma_payload_in(fpay(f_fid)), .fma_id_in(f_fid),
    .add_pending(f_ap), .add_request(f_areq),
    .add_payload(apay(f_aid)), .add_id(f_aid),
    .add_ready_out(f_ar), .adder_ready(f_rdy),
    .adder_new_request(f_nr), .adder_payload(f_pay), .adder_id(f_id),
    .fifo_count(f_cnt), .force_add(f_force)
  );

  fp_fma_add_arbiter #(.PAYLOAD_W(PW), .ID_W(IW), .DEPTH(2), .MAX_STREAK(0)) dut_s (
    .clk(clk), .rst(s_rst),
    .fma_valid_in(s_fv), .fma_ready_out(s_fr),
    .fma_payload_in(fpay(s_fid)), .fma_id_in(s_fid),
    .add_pending(s_ap), .add_request(s_areq),
    .add_payload(apay(s_aid)), .add_id(s_aid),
    .add_ready_out(s_ar), .adder_ready(s_rdy),
    .adder_new_request(s_nr), .adder_payload(s_pay), .adder_id(s_id),
    .fifo_count(s_cnt), .force_add(s_force)
  );

  function automatic vec_t mk(input logic rst, fv, input logic [2:0] fid,
                              input logic ap, areq, input logic [2:0] aid, input logic rdy,
                              input logic e_fr, e_ar, e_nr, input logic [2:0] e_id,
                              input logic e_add, input logic [1:0] e_cnt, input logic e_force);
    vec_t v;
    v.rst = rst; v.fv = fv; v.fid = fid; v.ap = ap; v.areq = areq; v.aid = aid; v.rdy = rdy;
    v.e_fr = e_fr; v.e_ar = e_ar; v.e_nr = e_nr; v.e_id = e_id; v.e_add = e_add;
    v.e_cnt = e_cnt; v.e_force = e_force;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input bit use_s, input int row);
    logic fr, ar, nr, frc;
    logic [IW-1:0] id;
    logic [PW-1:0] pay;
    logic [1:0] cnt;
    @(negedge clk);
    if (use_s) begin
      s_rst = v.rst; s_fv = v.fv; s_fid = v.fid; s_ap = v.ap;
      s_areq = v.areq; s_aid = v.aid; s_rdy = v.rdy;
    end else begin
      f_rst = v.rst; f_fv = v.fv; f_fid = v.fid; f_ap = v.ap;
      f_areq = v.areq; f_aid = v.aid; f_rdy = v.rdy;
    end
    #2;
    if (use_s) begin
      fr = s_fr; ar = s_ar; nr = s_nr; frc = s_force; id = s_id; pay = s_pay; cnt = s_cnt;
    end else begin
      fr = f_fr; ar = f_ar; nr = f_nr; frc = f_force; id = f_id; pay = f_pay; cnt = f_cnt;
    end
    chk("fma_ready_out", row, PW'(fr), PW'(v.e_fr));
    chk("add_ready_out", row, PW'(ar), PW'(v.e_ar));
    chk("adder_new_request", row, PW'(nr), PW'(v.e_nr));
    chk("fifo_count", row, PW'(cnt), PW'(v.e_cnt));
    chk("force_add", row, PW'(frc), PW'(v.e_force));
    if (v.e_nr) begin
      chk("adder_id", row, PW'(id), PW'(v.e_id));
      chk("adder_payload", row, pay, v.e_add ? apay(v.e_id) : fpay(v.e_id));
    end
  endtask

  vec_t fq[$];
  vec_t sq[$];

  initial begin
    // reset state
    fq.push_back(mk(0,0,0,0,0,0,1, 1,1,0,0,0,0,0));
`ifndef FP_FMA_BYPASS_EN
    // single FMA through the FIFO: one cycle latency
    fq.push_back(mk(0,1,5,0,0,0,1, 1,1,0,0,0,0,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,0,1,5,0,1,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,1,0,0,0,0,0));
`else
    // bypass: same-cycle hand-off, FIFO untouched, adds blocked
    fq.push_back(mk(0,1,4,0,0,0,1, 1,0,1,4,0,0,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,1,0,0,0,0,0));
`endif
    // full FIFO with simultaneous push and pop
    fq.push_back(mk(0,1,1,0,0,0,0, 1,0,0,0,0,0,0));
    fq.push_back(mk(0,1,2,0,0,0,0, 1,0,0,0,0,1,0));
    fq.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,2,0));
    fq.push_back(mk(0,1,3,0,0,0,1, 1,0,1,1,0,2,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,0,1,2,0,2,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,0,1,3,0,1,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,1,0,0,0,0,0));
    // fairness: two FMA grants, then a forced add, then streak restarts
    fq.push_back(mk(0,1,1,0,0,0,0, 1,0,0,0,0,0,0));
    fq.push_back(mk(0,1,2,0,0,0,0, 1,0,0,0,0,1,0));
    fq.push_back(mk(0,1,3,1,0,0,1, 1,0,1,1,0,2,0));
    fq.push_back(mk(0,1,4,1,0,0,1, 1,0,1,2,0,2,0));
    fq.push_back(mk(0,1,5,1,1,6,1, 0,1,1,6,1,2,1));
    fq.push_back(mk(0,1,5,1,0,0,1, 1,0,1,3,0,2,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,0,1,4,0,2,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,0,1,5,0,1,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,1,0,0,0,0,0));
    // reset with a full FIFO discards entries
    fq.push_back(mk(0,1,1,0,0,0,0, 1,0,0,0,0,0,0));
    fq.push_back(mk(0,1,2,0,0,0,0, 1,0,0,0,0,1,0));
    fq.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,2,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,1,0,0,0,0,0));
    fq.push_back(mk(0,0,0,0,0,0,1, 1,1,0,0,0,0,0));

    // strict priority: the add waits until the FIFO fully drains
    sq.push_back(mk(0,0,0,0,0,0,1, 1,1,0,0,0,0,0));
    sq.push_back(mk(0,1,1,0,0,0,0, 1,0,0,0,0,0,0));
    sq.push_back(mk(0,1,2,0,0,0,0, 1,0,0,0,0,1,0));
    sq.push_back(mk(0,1,3,1,0,0,1, 1,0,1,1,0,2,0));
    sq.push_back(mk(0,1,4,1,0,0,1, 1,0,1,2,0,2,0));
    sq.push_back(mk(0,0,0,1,0,0,1, 1,0,1,3,0,2,0));
    sq.push_back(mk(0,0,0,1,0,0,1, 1,0,1,4,0,1,0));
    sq.push_back(mk(0,0,0,1,1,6,1, 1,1,1,6,1,0,0));
    sq.push_back(mk(0,0,0,0,0,0,1, 1,1,0,0,0,0,0));

    f_rst = 1'b1; f_fv = 1'b0; f_fid = '0; f_ap = 1'b0; f_areq = 1'b0; f_aid = '0; f_rdy = 1'b1;
    s_rst = 1'b1; s_fv = 1'b0; s_fid = '0; s_ap = 1'b0; s_areq = 1'b0; s_aid = '0; s_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_rst = 1'b0;

    for (int i = 0; i < fq.size(); i++) run(fq[i], 1'b0, i);
    for (int i = 0; i < sq.size(); i++) run(sq[i], 1'b1, i);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_fma_add_arbiter.md
Name: fp_fma_add_arbiter

Overview:
- Parametrised successor to the single-register FMA hand-off in the FP multiply-add wrapper.
- Buffers multiplier-generated FMA addend operands in a DEPTH-entry FIFO and arbitrates them against directly issued FP add instructions onto the single FP adder issue port.
- Adds a bounded-starvation fairness counter and, optionally, a zero-latency FIFO bypass.
- Sits between fp_mul (FMA output stream), the unit issue port (add requests) and fp_add (issue input).

Parameters:
- PAYLOAD_W, 128: width of the adder operand bundle (fp_add_inputs_t packed).
- ID_W, 3: instruction id width.
- DEPTH, 2: FMA FIFO entries. Must be ≥1; need not be a power of two.
- MAX_STREAK, 4: consecutive FMA grants allowed while an add is pending before one add is forced. 0 means strict FMA priority with no fairness.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- fma_valid_in in 1: multiplier presents an FMA addend operand set.
- fma_ready_out out 1: arbiter accepts the FMA operand set this cycle.
- fma_payload_in in PAYLOAD_W: FMA operands for the adder.
- fma_id_in in ID_W: FMA instruction id.
- add_pending in 1: issue stage holds an add instruction. Level signal, independent of ready.
- add_request in 1: add issued this cycle (issue new_request & add). Only asserted when add_ready_out=1.
- add_payload in PAYLOAD_W: add operands.
- add_id in ID_W: add instruction id.
- add_ready_out out 1: adder slot available to an add this cycle.
- adder_ready in 1: fp_add issue ready.
- adder_new_request out 1: request to fp_add.
- adder_payload out PAYLOAD_W: operands to fp_add.
- adder_id out ID_W: id to fp_add.
- fifo_count out $clog2(DEPTH+1): occupied entries.
- force_add out 1: fairness override active this cycle (debug/perf).

Behaviour:
- **FIFO**
  - Circular buffer. Read and write pointers wrap from DEPTH-1 to 0.
  - Push = fma_valid_in & fma_ready_out & ~bypass_take.
  - Pop = fma_grant & FIFO non-empty.
  - Push and pop in the same cycle leaves count unchanged; this is legal when full.
- **fma_ready_out** = (fifo_count < DEPTH) | pop. This path is combinational through adder_ready, which is acceptable.
- **force_add** = (MAX_STREAK != 0) & add_pending & (streak == MAX_STREAK).
- **add_ready_out** = adder_ready & (fifo_empty | force_add) & ~bypass_take.
  - Never depends on add_request, so there is no combinational loop.
- **Grant priority, each cycle:**
  1. force_add & add_request → add.
  2. Else FIFO non-empty & adder_ready & ~force_add → FIFO head.
  3. Else bypass_take → fma input (see Optional Feature).
  4. Else add_request → add.
- **Adder outputs**
  - adder_new_request = any grant.
  - adder_payload / adder_id come from the granted source. They are don't-care when there is no grant but driven from the FIFO head.
  - All adder outputs are combinational; there is no output register.
- **Fairness counter `streak`** (width $clog2(MAX_STREAK+1)):
  - +1 on each FMA grant while add_pending, saturating at MAX_STREAK.
  - Cleared on an add grant, or in any cycle with add_pending=0.
- **Latency**
  - FMA operand: minimum 1 cycle from acceptance to adder_new_request without bypass.
  - Add: 0 cycles. The grant is in the same cycle as add_request.
- **Reset:** FIFO pointers, fifo_count and streak go to 0. With adder_ready=1 this gives fma_ready_out=1, force_add=0, add_ready_out=1. adder_new_request=0 unless add_request.
- **Reset mid-operation:** buffered FMA entries are discarded. The pipeline flush is owned by the surrounding unit.
- **Ordering:** FMA entries leave in acceptance order. There is no reordering between FMA entries.

Optional Feature:
- Macro: FP_FMA_BYPASS_EN.
- **Defined:**
  - bypass_take = fma_valid_in & fifo_empty & adder_ready & ~force_add.
  - The FMA operand goes straight to the adder in the same cycle and is not written to the FIFO. This is zero-cycle FMA hand-off latency.
- **Undefined:** bypass_take = 0. Every FMA operand is registered through the FIFO (≥1 cycle latency).

Test Plan:
1. **Reset, FIFO path.** Reset, then fma_valid_in=1, id=5, adder_ready=1, bypass off → fifo_count=1 next cycle. adder_new_request=1 with adder_id=5 one cycle after acceptance, then fifo_count=0.
2. **Full with simultaneous pop.** DEPTH=2, adder_ready=0, push ids 1,2 → fifo_count=2, fma_ready_out=0. Raise adder_ready with fma_valid_in (id 3) → pop id 1 and push id 3 in the same cycle; count stays 2; output order 1,2,3.
3. **Fairness.** MAX_STREAK=2, FIFO kept non-empty, add_pending=1 → add_ready_out=0 for 2 FMA grants. force_add=1 on the 3rd cycle; add_request with id 6 is granted (adder_id=6) and streak clears.
4. **Strict priority.** MAX_STREAK=0, same stimulus as scenario 3 → add_ready_out stays 0 until the FIFO drains; force_add is never 1.
5. **Bypass.** FP_FMA_BYPASS_EN, FIFO empty, adder_ready=1, fma_valid_in id 4 → adder_new_request=1 with adder_id=4 in the same cycle; fifo_count stays 0; add_ready_out=0 that cycle.
6. **Reset mid-operation.** Assert rst with fifo_count=2 → next cycle fifo_count=0, fma_ready_out=1, no stale id is emitted afterwards.
